// File: rtl/mem_pkg.sv
// Shared types and helpers for the burst memory model.
// Geometry localparams describe the default configuration (64b beats, 2-beat lines, 23b address).
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_WR_BURST = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_W     = 23;
  localparam int unsigned DEF_BEAT_W     = 64;
  localparam int unsigned DEF_LINE_BEATS = 2;

  localparam int unsigned OFF_W  = $clog2(DEF_BEAT_W / 8);
  localparam int unsigned BI_W   = $clog2(DEF_LINE_BEATS);
  localparam int unsigned LINE_W = DEF_ADDR_W - OFF_W - BI_W;

  // Beat index reached after 'step' beats starting at 'start', wrapping inside the line.
  function automatic int unsigned wrap_beat(input int unsigned start,
                                            input int unsigned step,
                                            input int unsigned beats);
    return (start + step) % beats;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Line storage: one synchronous read port and one byte-enabled write port.
// A read of the word being written in the same cycle returns the merged new data.
module mem_array #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [WIDTH-1:0]   i_wr_data,
  input  logic [WIDTH/8-1:0] i_wr_be,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [WIDTH-1:0]   o_rd_data
);

  localparam int unsigned BYTES = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [WORDS];
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_merge;

  assign w_old = r_mem[i_rd_idx];

  // Old word with the enabled bytes replaced by the incoming write.
  always_comb begin
    w_merge = w_old;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (i_wr_be[b]) begin
        w_merge[b*8 +: 8] = i_wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (i_wr_be[b]) begin
          r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
        end
      end
    end
    r_q <= (i_we && (i_wr_idx == i_rd_idx)) ? w_merge : w_old;
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/burst_memory.sv
// Main-memory model serving whole-line bursts: critical-word-first reads after RD_LAT cycles.
// Optional MEM_WSTRB_EN adds the wr_strb byte-enable port.
module burst_memory
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned BEAT_W     = 64,
  parameter int unsigned LINE_BEATS = 2,
  parameter int unsigned DEPTH      = 2**19,
  parameter int unsigned RD_LAT     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [BEAT_W-1:0] wr_data,
`ifdef MEM_WSTRB_EN
  input  logic [BEAT_W/8-1:0] wr_strb,
`endif
  output logic              rd_valid,
  output logic [BEAT_W-1:0] rd_data,
  output logic              rd_last,
  output logic              err
);

  localparam int unsigned STRB_W    = BEAT_W / 8;
  localparam int unsigned OFF_BITS  = $clog2(STRB_W);
  localparam int unsigned BI_BITS   = $clog2(LINE_BEATS);
  localparam int unsigned LINE_BITS = ADDR_W - OFF_BITS - BI_BITS;
  localparam int unsigned IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned BCNT_BITS = BI_BITS + 1;
  localparam int unsigned ARR_IDX_W = IDX_BITS + BI_BITS;

  state_e                 r_state;
  logic [CNT_BITS-1:0]    r_lat_cnt;
  logic [BCNT_BITS-1:0]   r_beat_cnt;
  logic [LINE_BITS-1:0]   r_line;
  logic [BI_BITS-1:0]     r_start;
  logic                   r_line_err;
  logic                   r_req_ready;
  logic                   r_wr_ready;
  logic                   r_rd_valid;
  logic                   r_rd_last;
  logic                   r_err;
  logic [BEAT_W-1:0]      r_rd_data;

  logic [LINE_BITS-1:0]   w_req_line;
  logic [BI_BITS-1:0]     w_req_bi;
  logic                   w_req_oor;
  logic                   w_accept;
  logic                   w_wr_fire;
  logic                   w_we;
  logic [LINE_BITS-1:0]   w_rd_line;
  logic [BI_BITS-1:0]     w_rd_bi;
  logic [BI_BITS-1:0]     w_wr_bi;
  logic [ARR_IDX_W-1:0]   w_rd_idx;
  logic [ARR_IDX_W-1:0]   w_wr_idx;
  logic [BEAT_W-1:0]      w_q;
  logic [STRB_W-1:0]      w_strb;
  logic                   w_unused_off;

  function automatic logic [BI_BITS-1:0] beat_at(input logic [BI_BITS-1:0]   start,
                                                 input logic [BCNT_BITS-1:0] step);
    return BI_BITS'(wrap_beat(32'(start), 32'(step), LINE_BEATS));
  endfunction

  assign w_req_line   = req_addr[ADDR_W-1 -: LINE_BITS];
  assign w_req_bi     = req_addr[OFF_BITS +: BI_BITS];
  assign w_req_oor    = 64'(w_req_line) >= 64'(DEPTH);
  assign w_accept     = req_valid && r_req_ready;
  assign w_wr_fire    = (r_state == ST_WR_BURST) && wr_valid && r_wr_ready;
  assign w_we         = w_wr_fire && !r_line_err;
  assign w_unused_off = ^req_addr[OFF_BITS-1:0];

`ifdef MEM_WSTRB_EN
  assign w_strb = wr_strb;
`else
  assign w_strb = '1;
`endif

  // The array read runs one cycle ahead of rd_data, so the address leads the output beat.
  always_comb begin
    w_rd_line = r_line;
    w_rd_bi   = r_start;
    unique case (r_state)
      ST_IDLE: begin
        w_rd_line = w_req_line;
        w_rd_bi   = w_req_bi;
      end
      ST_WAIT:     w_rd_bi = (r_lat_cnt == '0) ? beat_at(r_start, BCNT_BITS'(1)) : r_start;
      ST_RD_BURST: w_rd_bi = beat_at(r_start, r_beat_cnt + 1'b1);
      default:     w_rd_bi = r_start;
    endcase
  end

  assign w_wr_bi  = beat_at(r_start, r_beat_cnt);
  assign w_rd_idx = {IDX_BITS'(w_rd_line), w_rd_bi};
  assign w_wr_idx = {IDX_BITS'(r_line), w_wr_bi};

  mem_array #(
    .WORDS (DEPTH * LINE_BEATS),
    .IDX_W (ARR_IDX_W),
    .WIDTH (BEAT_W)
  ) u_array (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (wr_data),
    .i_wr_be   (w_strb),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_q)
  );

  // Request FSM with latency/beat counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_line      <= '0;
      r_start     <= '0;
      r_line_err  <= 1'b0;
      r_req_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_err       <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_line      <= w_req_line;
            r_start     <= w_req_bi;
            r_line_err  <= w_req_oor;
            r_err       <= w_req_oor;
            r_beat_cnt  <= '0;
            if (req_rw) begin
              r_state   <= ST_WAIT;
              r_lat_cnt <= CNT_BITS'(RD_LAT - 1);
            end else begin
              r_state    <= ST_WR_BURST;
              r_wr_ready <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_state    <= ST_RD_BURST;
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_line_err ? '0 : w_q;
            r_beat_cnt <= BCNT_BITS'(1);
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        ST_RD_BURST: begin
          if (r_beat_cnt == BCNT_BITS'(LINE_BEATS)) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_line_err ? '0 : w_q;
            r_rd_last  <= (r_beat_cnt == BCNT_BITS'(LINE_BEATS - 1));
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        ST_WR_BURST: begin
          if (w_wr_fire) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (r_beat_cnt == BCNT_BITS'(LINE_BEATS - 1)) begin
              r_state     <= ST_IDLE;
              r_wr_ready  <= 1'b0;
              r_req_ready <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_data   = r_rd_data;
  assign err       = r_err;

endmodule

// File: tb/tb_burst_memory.sv
// Directed bench for burst_memory (64b beats, 2-beat lines, RD_LAT=4, DEPTH=64 lines).
// Define MEM_WSTRB_EN to also exercise byte strobes.
module tb_burst_memory;

  localparam int unsigned RD_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [22:0] req_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
`ifdef MEM_WSTRB_EN
  logic [7:0]  wr_strb;
`endif
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  burst_memory #(
    .ADDR_W     (23),
    .BEAT_W     (64),
    .LINE_BEATS (2),
    .DEPTH      (64),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
`ifdef MEM_WSTRB_EN
    .wr_strb   (wr_strb),
`endif
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .err       (err)
  );

  typedef struct {
    bit          wr;
    logic [22:0] addr;
    logic [63:0] b0;
    logic [63:0] b1;
    int          exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
  endtask

  task automatic do_read(input logic [22:0] a,
                         output logic [63:0] d0, output logic [63:0] d1,
                         output logic l0, output logic l1, output logic v1,
                         output int lat, output int errc, output logic busy,
                         output logic vld_after, output logic [63:0] hold,
                         output logic rdy_after);
    wait_ready();
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    busy = req_ready;
    errc = int'(err);
    lat  = 0;
    while (!rd_valid && lat < 64) begin
      step();
      lat++;
      if (err) errc++;
    end
    d0 = rd_data;
    l0 = rd_last;
    step();
    if (err) errc++;
    v1 = rd_valid;
    d1 = rd_data;
    l1 = rd_last;
    step();
    vld_after = rd_valid;
    hold      = rd_data;
    rdy_after = req_ready;
  endtask

  task automatic do_write(input logic [22:0] a, input logic [63:0] d0, input logic [63:0] d1,
                          input int gap, output int errc, output logic stall_ok,
                          output logic wr_rdy_end, output logic rdy_end);
    int n = 0;
    wait_ready();
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    errc      = int'(err);
    wr_valid  = 1'b1;
    wr_data   = d0;
    step();
    if (err) errc++;
    stall_ok = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '1;
    repeat (gap) begin
      step();
      if (!wr_ready) stall_ok = 1'b0;
    end
    wr_valid = 1'b1;
    wr_data  = d1;
    while (!wr_ready && n < 50) begin
      step();
      n++;
    end
    step();
    wr_valid   = 1'b0;
    wr_rdy_end = wr_ready;
    rdy_end    = req_ready;
  endtask

  task automatic read_expect(input string nm, input logic [22:0] a,
                             input logic [63:0] e0, input logic [63:0] e1, input int e_err);
    logic [63:0] d0, d1, hold;
    logic l0, l1, v1, busy, va, ra;
    int lat, errc;
    do_read(a, d0, d1, l0, l1, v1, lat, errc, busy, va, hold, ra);
    chk({nm, ".beat0"}, d0, e0);
    chk({nm, ".beat1"}, d1, e1);
    chk({nm, ".latency"}, 64'(lat), 64'(RD_LAT));
    chk({nm, ".last_pattern"}, {62'd0, v1, l1, l0} == 3'b110 ? 64'd1 : 64'd0, 64'd1);
    chk({nm, ".err_pulses"}, 64'(errc), 64'(e_err));
    chk({nm, ".busy_ready"}, 64'(busy), 64'd0);
    chk({nm, ".end_valid"}, 64'(va), 64'd0);
    chk({nm, ".hold_data"}, hold, e1);
    chk({nm, ".ready_back"}, 64'(ra), 64'd1);
  endtask

  task automatic write_expect(input string nm, input logic [22:0] a, input logic [63:0] d0,
                              input logic [63:0] d1, input int gap, input int e_err);
    int errc;
    logic stall_ok, wre, rre;
    do_write(a, d0, d1, gap, errc, stall_ok, wre, rre);
    chk({nm, ".err_pulses"}, 64'(errc), 64'(e_err));
    chk({nm, ".stall_wr_ready"}, 64'(stall_ok), 64'd1);
    chk({nm, ".wr_ready_drop"}, 64'(wre), 64'd0);
    chk({nm, ".req_ready_back"}, 64'(rre), 64'd1);
  endtask

  localparam logic [63:0] A = 64'hAAAA_0001_0000_000A;
  localparam logic [63:0] B = 64'hBBBB_0002_0000_000B;
  localparam logic [63:0] C = 64'hCCCC_0003_0000_000C;
  localparam logic [63:0] D = 64'hDDDD_0004_0000_000D;
  localparam logic [63:0] G = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] H = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] P = 64'h5555_6666_7777_8888;
  localparam logic [63:0] Q = 64'h9999_AAAA_BBBB_CCCC;

  initial begin
    vec_t vecs[9];
    logic [63:0] d0, d1, hold;
    logic l0, l1, v1, busy, va, ra;
    int lat, errc;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
`ifdef MEM_WSTRB_EN
    wr_strb   = 8'hFF;
`endif

    // Reset held for three cycles; everything quiet, req_ready one edge after release.
    repeat (3) step();
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.wr_ready", 64'(wr_ready), 64'd0);
    chk("rst.rd_valid", 64'(rd_valid), 64'd0);
    chk("rst.rd_last", 64'(rd_last), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.rd_data", rd_data, 64'd0);
    rst_n = 1'b1;
    chk("rst.ready_before_edge", 64'(req_ready), 64'd0);
    step();
    chk("rst.ready_after_edge", 64'(req_ready), 64'd1);

    // Line = addr>>4; DEPTH=64 so addresses 0x400 and above are out of range.
    vecs[0] = '{1'b1, 23'h000100, A, B, 0};
    vecs[1] = '{1'b0, 23'h000108, B, A, 0};
    vecs[2] = '{1'b0, 23'h000100, A, B, 0};
    vecs[3] = '{1'b1, 23'h0003F8, C, D, 0};
    vecs[4] = '{1'b0, 23'h0003F0, D, C, 0};
    vecs[5] = '{1'b1, 23'h000000, G, H, 0};
    vecs[6] = '{1'b1, 23'h000400, P, Q, 1};
    vecs[7] = '{1'b0, 23'h000000, G, H, 0};
    vecs[8] = '{1'b0, 23'h000400, 64'd0, 64'd0, 1};

    foreach (vecs[i]) begin
      if (vecs[i].wr)
        write_expect($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].b0, vecs[i].b1, 0, vecs[i].exp_err);
      else
        read_expect($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].b0, vecs[i].b1, vecs[i].exp_err);
    end

    // Stalled write burst, then stray wr_valid while idle must not disturb the line.
    write_expect("stall_wr", 23'h000200, P, Q, 3, 0);
    wr_valid = 1'b1;
    wr_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) step();
    wr_valid = 1'b0;
    read_expect("stall_rd", 23'h000200, P, Q, 0);

    // Reset on the second beat of a read aborts it at once; stored data survives.
    do_read(23'h000100, d0, d1, l0, l1, v1, lat, errc, busy, va, hold, ra);
    wait_ready();
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 23'h000100;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rd_valid && lat < 64) begin
      step();
      lat++;
    end
    chk("abort.first_beat", rd_data, A);
    step();
    chk("abort.second_beat_valid", 64'(rd_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.rd_valid", 64'(rd_valid), 64'd0);
    chk("abort.rd_last", 64'(rd_last), 64'd0);
    chk("abort.rd_data", rd_data, 64'd0);
    chk("abort.req_ready", 64'(req_ready), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    read_expect("abort_reread", 23'h000100, A, B, 0);

`ifdef MEM_WSTRB_EN
    // Low four byte lanes only.
    write_expect("strb_base", 23'h000300, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 0, 0);
    wr_strb = 8'h0F;
    write_expect("strb_over", 23'h000300, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    wr_strb = 8'h00;
    write_expect("strb_zero", 23'h000300, 64'h0, 64'h0, 0, 0);
    wr_strb = 8'hFF;
    read_expect("strb_rd", 23'h000300, 64'h1111_1111_FFFF_FFFF, 64'h1111_1111_FFFF_FFFF, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
